// File: rtl/cbs_credit_gate.sv
// Credit-based shaper gate for one traffic class on an AXI4-Stream egress path.
// Optional statistics counters are enabled by defining CBS_CREDIT_GATE_STATS_EN.
module cbs_credit_gate #(
    parameter int C_AXIS_TDATA_WIDTH = 8,
    parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
    parameter int CREDIT_WIDTH       = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    input  logic                          output_side_ready,
    input  logic [CREDIT_WIDTH-1:0]       idle_slope,
    input  logic [CREDIT_WIDTH-1:0]       send_slope,
    input  logic [CREDIT_WIDTH-1:0]       hi_credit,
    input  logic [CREDIT_WIDTH-1:0]       lo_credit,
    output logic [CREDIT_WIDTH-1:0]       credit,
`ifdef CBS_CREDIT_GATE_STATS_EN
    output logic [31:0]                   stat_frames,
    output logic [31:0]                   stat_wait_cycles,
`endif
    output logic                          gate_open
);

    localparam int EW = CREDIT_WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TX   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CREDIT_WIDTH-1:0]  credit_q, credit_d;
    logic                     gate_open_q, gate_open_d;

    logic                     beat;
    logic                     pending;
    logic                     credit_neg;
    logic signed [EW-1:0]     credit_ext, idle_ext, send_ext, hi_ext, lo_ext, sum_ext;

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tvalid = s_axis_tvalid & gate_open_q;
    assign s_axis_tready = m_axis_tready & gate_open_q;

    assign beat       = m_axis_tvalid & m_axis_tready;
    assign pending    = s_axis_tvalid;
    assign credit_neg = credit_q[CREDIT_WIDTH-1];

    assign credit    = credit_q;
    assign gate_open = gate_open_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    state_d = credit_neg ? ST_WAIT : ST_TX;
                end
            end
            ST_WAIT: begin
                if (!credit_neg) begin
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                if (beat && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        gate_open_d = (state_d == ST_TX);
    end

    // Two spare bits keep the sum exact for any slope before clamping.
    always_comb begin
        credit_ext = {{2{credit_q[CREDIT_WIDTH-1]}}, credit_q};
        idle_ext   = {2'b00, idle_slope};
        send_ext   = {2'b00, send_slope};
        hi_ext     = {{2{hi_credit[CREDIT_WIDTH-1]}}, hi_credit};
        lo_ext     = {{2{lo_credit[CREDIT_WIDTH-1]}}, lo_credit};
        sum_ext    = credit_ext;
        if (beat) begin
            sum_ext = credit_ext - send_ext;
        end else if (output_side_ready && (pending || credit_neg)) begin
            sum_ext = credit_ext + idle_ext;
        end else if (state_q == ST_IDLE && !pending && !credit_neg && credit_q != '0) begin
            sum_ext = '0;
        end
        if (sum_ext > hi_ext) begin
            credit_d = hi_credit;
        end else if (sum_ext < lo_ext) begin
            credit_d = lo_credit;
        end else begin
            credit_d = sum_ext[CREDIT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            credit_q    <= '0;
            gate_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            gate_open_q <= gate_open_d;
        end
    end

`ifdef CBS_CREDIT_GATE_STATS_EN
    logic [31:0] stat_frames_q, stat_frames_d;
    logic [31:0] stat_wait_cycles_q, stat_wait_cycles_d;

    always_comb begin
        stat_frames_d      = stat_frames_q;
        stat_wait_cycles_d = stat_wait_cycles_q;
        if (beat && s_axis_tlast && !(&stat_frames_q)) begin
            stat_frames_d = stat_frames_q + 32'd1;
        end
        if (state_q == ST_WAIT && !(&stat_wait_cycles_q)) begin
            stat_wait_cycles_d = stat_wait_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_frames_q      <= '0;
            stat_wait_cycles_q <= '0;
        end else begin
            stat_frames_q      <= stat_frames_d;
            stat_wait_cycles_q <= stat_wait_cycles_d;
        end
    end

    assign stat_frames      = stat_frames_q;
    assign stat_wait_cycles = stat_wait_cycles_q;
`endif

endmodule

// File: tb/tb_cbs_credit_gate.sv
// Self-checking bench for cbs_credit_gate: directed scenarios plus randomized
// traffic compared against a behavioural credit/gate model.
module tb_cbs_credit_gate;

    logic        clk;
    logic        rstn;
    logic [7:0]  s_tdata;
    logic [0:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [7:0]  m_tdata;
    logic [0:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        osr;
    logic [31:0] idle_slope;
    logic [31:0] send_slope;
    logic [31:0] hi_credit;
    logic [31:0] lo_credit;
    logic [31:0] credit;
    logic        gate_open;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = holding, 1 = waiting for credit, 2 = sending a frame
    int     m_phase;
    longint m_credit;

    cbs_credit_gate #(
        .C_AXIS_TDATA_WIDTH(8),
        .C_AXIS_TKEEP_WIDTH(1),
        .CREDIT_WIDTH(32)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast),
        .output_side_ready(osr),
        .idle_slope(idle_slope),
        .send_slope(send_slope),
        .hi_credit(hi_credit),
        .lo_credit(lo_credit),
        .credit(credit),
        .gate_open(gate_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint dut_credit();
        return longint'($signed(credit));
    endfunction

    task automatic model_step();
        longint c, nc, hi, lo;
        bit     sending, xfer;
        c       = m_credit;
        hi      = longint'($signed(hi_credit));
        lo      = longint'($signed(lo_credit));
        sending = (m_phase == 2);
        xfer    = s_tvalid && sending && m_tready;
        if (xfer)                             nc = c - longint'(send_slope);
        else if (osr && (s_tvalid || c < 0))  nc = c + longint'(idle_slope);
        else if (m_phase == 0 && !s_tvalid && c > 0) nc = 0;
        else                                  nc = c;
        if (nc > hi) nc = hi;
        else if (nc < lo) nc = lo;
        m_credit = nc;
        case (m_phase)
            0: if (s_tvalid) m_phase = (c >= 0) ? 2 : 1;
            1: if (c >= 0) m_phase = 2;
            default: if (xfer && s_tlast) m_phase = 0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstn) model_step();
        #1;
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 8'h00;
        s_tkeep  = 1'b1;
        m_tready = 1'b0;
        osr      = 1'b0;
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        m_phase  = 0;
        m_credit = 0;
    endtask

    task automatic set_cfg(input int idle_v, input int send_v, input int hi_v, input int lo_v);
        idle_slope = 32'(idle_v);
        send_slope = 32'(send_v);
        hi_credit  = 32'(hi_v);
        lo_credit  = 32'(lo_v);
    endtask

    task automatic test_reset();
        rstn = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1; osr = 1'b1;
        s_tdata = 8'h5A; s_tkeep = 1'b1; s_tlast = 1'b0;
        set_cfg(2, 6, 100, -100);
        #3;
        checks++;
        if (credit !== 32'd0) begin errors++; $display("[TB] FAIL reset_credit: got %0d expected 0", dut_credit()); end
        checks++;
        if (gate_open !== 1'b0) begin errors++; $display("[TB] FAIL reset_gate: got %b expected 0", gate_open); end
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
        checks++;
        if (s_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_tready: got %b expected 0", s_tready); end
        do_reset();
    endtask

    task automatic test_frame();
        do_reset();
        set_cfg(2, 6, 100, -100);
        s_tvalid = 1'b1; m_tready = 1'b1; osr = 1'b0; s_tdata = 8'h11;
        #1;
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL frame_held: m_tvalid got %b expected 0", m_tvalid); end
        tick();
        checks++;
        if (gate_open !== 1'b1) begin errors++; $display("[TB] FAIL frame_open_latency: gate got %b expected 1", gate_open); end
        for (int i = 0; i < 4; i++) begin
            s_tdata = 8'($urandom);
            s_tlast = (i == 3);
            #1;
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== s_tdata || m_tlast !== s_tlast) begin
                errors++;
                $display("[TB] FAIL frame_beat%0d: valid/data/last got %b/%h/%b expected 1/%h/%b",
                         i, m_tvalid, m_tdata, m_tlast, s_tdata, s_tlast);
            end
            tick();
        end
        checks++;
        if (dut_credit() != -24) begin errors++; $display("[TB] FAIL frame_credit: got %0d expected -24", dut_credit()); end
        checks++;
        if (gate_open !== 1'b0) begin errors++; $display("[TB] FAIL frame_close: gate got %b expected 0", gate_open); end
    endtask

    task automatic test_wait();
        int n;
        int leaks;
        n = 0; leaks = 0;
        s_tvalid = 1'b1; s_tlast = 1'b0; osr = 1'b1; m_tready = 1'b1;
        while (gate_open !== 1'b1 && n < 40) begin
            #1;
            if (m_tvalid !== 1'b0) leaks++;
            tick();
            n++;
        end
        checks++;
        if (n != 13) begin errors++; $display("[TB] FAIL wait_cycles: gate opened after %0d cycles expected 13", n); end
        checks++;
        if (leaks != 0) begin errors++; $display("[TB] FAIL wait_leak: %0d beats offered expected 0", leaks); end
        checks++;
        if (dut_credit() != 2) begin errors++; $display("[TB] FAIL wait_credit: got %0d expected 2", dut_credit()); end
        s_tlast = 1'b1;
        tick();
        checks++;
        if (dut_credit() != -4 || gate_open !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_frame_end: credit/gate got %0d/%b expected -4/0", dut_credit(), gate_open);
        end
    endtask

    task automatic test_hi_clamp();
        do_reset();
        set_cfg(2, 6, 100, -100);
        s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b0; osr = 1'b1;
        for (int i = 0; i < 60; i++) tick();
        checks++;
        if (dut_credit() != 100) begin errors++; $display("[TB] FAIL hi_clamp: got %0d expected 100", dut_credit()); end
        hi_credit = 32'd40; osr = 1'b0;
        tick();
        checks++;
        if (dut_credit() != 40) begin errors++; $display("[TB] FAIL hi_reclamp: got %0d expected 40", dut_credit()); end
        send_slope = 32'd0; m_tready = 1'b1; s_tlast = 1'b1;
        tick();
        checks++;
        if (dut_credit() != 40 || gate_open !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hi_frame_end: credit/gate got %0d/%b expected 40/0", dut_credit(), gate_open);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        tick();
        checks++;
        if (dut_credit() != 0) begin errors++; $display("[TB] FAIL idle_zero: got %0d expected 0", dut_credit()); end
    endtask

    task automatic test_stall();
        do_reset();
        set_cfg(2, 6, 100, -100);
        s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1; osr = 1'b0; s_tdata = 8'hA5;
        tick();
        tick();
        s_tdata = 8'h3C; s_tlast = 1'b1; m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 8'h3C || m_tlast !== 1'b1 || s_tready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: valid/data/last/ready got %b/%h/%b/%b expected 1/3c/1/0",
                         i, m_tvalid, m_tdata, m_tlast, s_tready);
            end
            tick();
        end
        checks++;
        if (dut_credit() != -6 || gate_open !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_credit: credit/gate got %0d/%b expected -6/1", dut_credit(), gate_open);
        end
        m_tready = 1'b1;
        tick();
        checks++;
        if (dut_credit() != -12 || gate_open !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_resume: credit/gate got %0d/%b expected -12/0", dut_credit(), gate_open);
        end
    endtask

    task automatic test_lo_clamp();
        int beats;
        int closed;
        beats = 0; closed = 0;
        do_reset();
        set_cfg(2, 6, 100, -100);
        s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1; osr = 1'b0;
        tick();
        for (int i = 0; i < 40; i++) begin
            s_tlast = (i == 39);
            #1;
            if (m_tvalid === 1'b1 && m_tready === 1'b1) beats++;
            if (gate_open !== 1'b1) closed++;
            tick();
        end
        checks++;
        if (beats != 40 || closed != 0) begin
            errors++;
            $display("[TB] FAIL lo_intact: beats/closed got %0d/%0d expected 40/0", beats, closed);
        end
        checks++;
        if (dut_credit() != -100) begin errors++; $display("[TB] FAIL lo_clamp: got %0d expected -100", dut_credit()); end
        checks++;
        if (gate_open !== 1'b0) begin errors++; $display("[TB] FAIL lo_close: gate got %b expected 0", gate_open); end
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        set_cfg(2, 6, 100, -100);
        s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1; osr = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (dut_credit() != -12) begin errors++; $display("[TB] FAIL pre_reset_credit: got %0d expected -12", dut_credit()); end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (credit !== 32'd0 || gate_open !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: credit/gate/valid got %0d/%b/%b expected 0/0/0",
                     dut_credit(), gate_open, m_tvalid);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1; m_phase = 0; m_credit = 0;
        s_tvalid = 1'b0;
    endtask

    task automatic test_random();
        int bad;
        for (int cfg = 0; cfg < 4; cfg++) begin
            do_reset();
            if (cfg == 3) begin
                idle_slope = $urandom; send_slope = $urandom;
                hi_credit  = 32'h7FFF_FFFF; lo_credit = 32'h8000_0000;
            end else begin
                set_cfg($urandom_range(0, 20), $urandom_range(0, 40),
                        $urandom_range(0, 300), -$urandom_range(0, 300));
            end
            bad = 0;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    if (cfg == 3) begin idle_slope = $urandom; send_slope = $urandom; end
                    else set_cfg($urandom_range(0, 20), $urandom_range(0, 40),
                                 $urandom_range(0, 300), -$urandom_range(0, 300));
                end
                s_tvalid = ($urandom_range(0, 3) != 0);
                s_tlast  = ($urandom_range(0, 4) == 0);
                m_tready = ($urandom_range(0, 3) != 0);
                osr      = $urandom_range(0, 1);
                s_tdata  = 8'($urandom);
                s_tkeep  = 1'($urandom);
                #1;
                checks++;
                if (dut_credit() != m_credit || gate_open !== (m_phase == 2) ||
                    m_tvalid !== (s_tvalid && m_phase == 2) || s_tready !== (m_tready && m_phase == 2) ||
                    m_tdata !== s_tdata || m_tkeep !== s_tkeep || m_tlast !== s_tlast) begin
                    errors++;
                    if (bad < 5)
                        $display("[TB] FAIL random_cfg%0d_cyc%0d: credit/gate/valid/ready got %0d/%b/%b/%b expected %0d/%b/%b/%b",
                                 cfg, i, dut_credit(), gate_open, m_tvalid, s_tready,
                                 m_credit, (m_phase == 2), (s_tvalid && m_phase == 2), (m_tready && m_phase == 2));
                    bad++;
                end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_wait();
        test_hi_clamp();
        test_stall();
        test_lo_clamp();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbs_credit_gate.md
Name: cbs_credit_gate

Overview:
Credit-based shaper (IEEE 802.1Qav style) gate for one traffic class on an 8-bit-multiple AXI4-Stream egress path.
- Holds frames at the ingress side until the signed credit counter is >= 0, then passes one whole frame unmodified.
- Updates credit from accepted beats and from the extracted downstream ready tap.
- Sits between the class queue and the egress arbiter. Its output_side_ready input is driven by the ready-extraction tap on the arbiter side.

Parameters:
C_AXIS_TDATA_WIDTH, 8, stream data width in bits (multiple of 8)
C_AXIS_TKEEP_WIDTH, C_AXIS_TDATA_WIDTH/8, tkeep width
CREDIT_WIDTH, 32, signed credit and slope/limit width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s_axis_tdata  in  C_AXIS_TDATA_WIDTH  ingress data
s_axis_tkeep  in  C_AXIS_TKEEP_WIDTH  ingress keep
s_axis_tvalid  in  1  ingress valid
s_axis_tready  out  1  ingress ready
s_axis_tlast  in  1  ingress end of frame
m_axis_tdata  out  C_AXIS_TDATA_WIDTH  egress data
m_axis_tkeep  out  C_AXIS_TKEEP_WIDTH  egress keep
m_axis_tvalid  out  1  egress valid
m_axis_tready  in  1  egress ready
m_axis_tlast  out  1  egress end of frame
output_side_ready  in  1  link-available tap from the downstream ready extractor
idle_slope  in  CREDIT_WIDTH  unsigned credit gain per idle link cycle
send_slope  in  CREDIT_WIDTH  unsigned credit loss per transferred beat
hi_credit  in  CREDIT_WIDTH  signed upper clamp (>= 0)
lo_credit  in  CREDIT_WIDTH  signed lower clamp (<= 0)
credit  out  CREDIT_WIDTH  signed current credit, registered
gate_open  out  1  registered gate state (1 = TX)

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, credit=0, gate_open=0. With the gate closed, m_axis_tvalid=0 and s_axis_tready=0.
- Data path is combinational pass-through when gate_open=1:
  - m_axis_tdata/tkeep/tlast follow s_axis_*.
  - m_axis_tvalid = s_axis_tvalid & gate_open.
  - s_axis_tready = m_axis_tready & gate_open.
- beat = m_axis_tvalid & m_axis_tready. pending = s_axis_tvalid.
- States:
  - IDLE: if pending & credit >= 0, go to TX (gate_open=1 from the next cycle; 1-cycle decision latency). If pending & credit < 0, go to WAIT.
  - WAIT: gate closed. Go to TX the cycle after credit becomes >= 0.
  - TX: gate open. On a beat with tlast=1, go to IDLE and close the gate in the same registered update. No back-to-back frames without re-evaluation.
- Credit update each cycle, priority order:
  1. beat: credit -= send_slope.
  2. else if output_side_ready & (pending | credit < 0): credit += idle_slope.
  3. else if state==IDLE & !pending & credit > 0: credit = 0.
  4. else: hold.
- Arithmetic: operands sign-extended to CREDIT_WIDTH+2 bits, result clamped to [lo_credit, hi_credit]. No wrap-around under any slope value.
- Stalls: a TX cycle with m_axis_tready=0 gives no decrement and no increment, because output_side_ready is low.
- Slope or limit changes take effect on the next update. If credit is outside new limits, it is clamped on the next update.
- A frame in TX is never truncated, even if credit reaches lo_credit.
- Reset mid-frame returns to IDLE immediately. The remainder of the frame is held at ingress; upstream owns the discard.

Optional Feature:
- Macro: CBS_CREDIT_GATE_STATS_EN.
- Defined: adds outputs stat_frames[31:0] and stat_wait_cycles[31:0], both reset to 0.
  - stat_frames increments on each beat with tlast=1.
  - stat_wait_cycles increments each cycle in WAIT.
  - Both saturate at 0xFFFFFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- idle_slope=2, send_slope=6, hi=100, lo=-100, credit 0, 4-beat frame, m_tready=1 → gate opens 1 cycle after tvalid, 4 beats pass, credit=-24, state IDLE.
- Same config, second frame presented immediately, output_side_ready=1 → WAIT for 12 cycles, credit reaches 0, first beat on cycle 14.
- Credit +40, no pending, state IDLE → credit=0 next cycle. Pending with link idle for 60 cycles from 0 → credit clamps at 100.
- m_tready=0 for 5 cycles mid-frame → no transfers, credit constant, tdata/tlast held stable to output.
- 40-beat frame with send_slope=6 → credit clamps at -100, frame completes intact.
- rstn low for 1 cycle mid-frame → credit=0, gate_open=0, m_tvalid=0 asynchronously. With stats on, both counters read 0.
